uart_rx_irr: RTL and testbench

Serial receive peripheral that is the initiating end of the CPU's `irr`/`ack`/`rx_data` interface. It oversamples an asynchronous 8N1 UART line, assembles bytes LSB-first and holds each byte on `rx_data` while raising `irr`. It then runs a four-phase handshake against the CPU's level `ack`. A one-entry pending buffer absorbs a byte that completes while the CPU is still servicing the previous one. Instantiated at top level beside `cpu`, with outputs wired directly to the CPU's `irr` and `rx_data` inputs.

---
 rtl/uart_rx_irr.sv | 196 +++++++++++++++++++
 tb/tb_uart_rx_irr.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_irr.sv
// 8N1 UART receiver with 2-flop input synchronizer, one-entry pending buffer
// and a four-phase irr/ack request handshake toward the CPU.
module uart_rx_irr #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       ack,
  output logic       irr,
  output logic [7:0] rx_data,
  output logic       overrun,
  output logic       frame_err
);

  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_M1 = 16'((CLKS_PER_BIT / 2) - 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_e;
  typedef enum logic [1:0] {H_IDLE, H_REQ, H_WAIT} hs_state_e;

  logic        sync1_q, rxs_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  hs_state_e   hs_state_q, hs_state_d;
  logic        irr_q, irr_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic [7:0]  pend_q, pend_d;
  logic        pend_v_q, pend_v_d;
  logic        overrun_q, overrun_d;
  logic        frame_err_q, frame_err_d;
  logic        done_s, frame_set_s, ovr_set_s, clr_flags_s;

  // Receive FSM: start qualification, bit sampling, stop check and break wait
  always_comb begin
    rx_state_d  = rx_state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    done_s      = 1'b0;
    frame_set_s = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (!rxs_q) begin
          cnt_d      = 16'd0;
          rx_state_d = R_START;
        end else begin
          rx_state_d = R_IDLE;
        end
      end
      R_START: begin
        if (cnt_q == HALF_M1) begin
          if (rxs_q) begin
            rx_state_d = R_IDLE;
          end else begin
            cnt_d      = 16'd0;
            idx_d      = 3'd0;
            rx_state_d = R_DATA;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      R_DATA: begin
        if (cnt_q == FULL_M1) begin
          shift_d[idx_q] = rxs_q;
          cnt_d          = 16'd0;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            rx_state_d = R_STOP;
          end else begin
            rx_state_d = R_DATA;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      R_STOP: begin
        if (cnt_q == FULL_M1) begin
          if (rxs_q) begin
            done_s     = 1'b1;
            rx_state_d = R_IDLE;
          end else begin
            frame_set_s = 1'b1;
            rx_state_d  = R_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      R_BREAK: begin
        if (rxs_q) begin
          rx_state_d = R_IDLE;
        end else begin
          rx_state_d = R_BREAK;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // Handshake FSM, pending buffer and sticky flags (flag set beats clear)
  always_comb begin
    hs_state_d  = hs_state_q;
    rx_data_d   = rx_data_q;
    pend_d      = pend_q;
    pend_v_d    = pend_v_q;
    ovr_set_s   = 1'b0;
    clr_flags_s = 1'b0;
    case (hs_state_q)
      H_IDLE: begin
        if (pend_v_q && !ack) begin
          rx_data_d  = pend_q;
          pend_v_d   = 1'b0;
          hs_state_d = H_REQ;
        end else begin
          hs_state_d = H_IDLE;
        end
      end
      H_REQ: begin
        if (ack) begin
          hs_state_d  = H_WAIT;
          clr_flags_s = 1'b1;
        end else begin
          hs_state_d = H_REQ;
        end
      end
      H_WAIT: begin
        if (!ack) begin
          hs_state_d = H_IDLE;
        end else begin
          hs_state_d = H_WAIT;
        end
      end
      default: hs_state_d = H_IDLE;
    endcase
    // A completed byte goes straight out only when nothing is queued or in service
    if (done_s) begin
      if ((hs_state_q == H_IDLE) && !ack && !pend_v_q) begin
        rx_data_d  = shift_q;
        hs_state_d = H_REQ;
      end else if (!pend_v_q) begin
        pend_d   = shift_q;
        pend_v_d = 1'b1;
      end else begin
        ovr_set_s = 1'b1;
      end
    end else begin
      ovr_set_s = 1'b0;
    end
    irr_d       = (hs_state_d == H_REQ);
    overrun_d   = ovr_set_s | (overrun_q & ~clr_flags_s);
    frame_err_d = frame_set_s | (frame_err_q & ~clr_flags_s);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      rx_state_q  <= R_IDLE;
      cnt_q       <= 16'd0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      hs_state_q  <= H_IDLE;
      irr_q       <= 1'b0;
      rx_data_q   <= 8'h00;
      pend_q      <= 8'h00;
      pend_v_q    <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= rxd;
      rxs_q       <= sync1_q;
      rx_state_q  <= rx_state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      hs_state_q  <= hs_state_d;
      irr_q       <= irr_d;
      rx_data_q   <= rx_data_d;
      pend_q      <= pend_d;
      pend_v_q    <= pend_v_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign irr       = irr_q;
  assign rx_data   = rx_data_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_irr.sv
// Directed and randomized bench for uart_rx_irr against a byte-level
// reference model of delivery, pending buffer and sticky flags.
module tb_uart_rx_irr;
  localparam int C = 16;

  logic       clk = 1'b0;
  logic       reset, rxd, ack;
  logic       irr, overrun, frame_err;
  logic [7:0] rx_data;

  int n_chk = 0;
  int n_fail = 0;

  // byte-level reference model
  logic       m_valid;
  logic [7:0] m_data;
  logic [7:0] m_pend[$];
  logic       m_ovr, m_ferr;

  uart_rx_irr #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .ack(ack),
    .irr(irr), .rx_data(rx_data), .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_pend.delete();
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
  endtask

  // byte completes with ack low: deliver, queue, or drop
  task automatic model_frame(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok) m_ferr = 1'b1;
    else if (!m_valid) begin
      m_valid = 1'b1;
      m_data  = b;
    end else if (m_pend.size() == 0) m_pend.push_back(b);
    else m_ovr = 1'b1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".irr"}, {15'd0, irr}, {15'd0, m_valid});
    chk({tag, ".rx_data"}, {8'd0, rx_data}, {8'd0, m_data});
    chk({tag, ".overrun"}, {15'd0, overrun}, {15'd0, m_ovr});
    chk({tag, ".frame_err"}, {15'd0, frame_err}, {15'd0, m_ferr});
  endtask

  // start bit plus 8 data bits; returns at the start of the stop bit
  task automatic drive_bits(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(C);
    end
    rxd = stop;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bits(b, stop);
    tick(C);
  endtask

  // full four-phase handshake on the currently offered byte
  task automatic do_ack(input string tag);
    ack = 1'b1;
    tick(1);
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
    chk({tag, ".irr_fall"}, {15'd0, irr}, 16'd0);
    chk({tag, ".ovr_clr"}, {15'd0, overrun}, 16'd0);
    chk({tag, ".ferr_clr"}, {15'd0, frame_err}, 16'd0);
    ack = 1'b0;
    tick(1);
    chk({tag, ".irr_gap"}, {15'd0, irr}, 16'd0);
    tick(1);
    if (m_pend.size() != 0) begin
      m_valid = 1'b1;
      m_data  = m_pend.pop_front();
    end
    check_model({tag, ".next"});
  endtask

  initial begin
    logic [7:0] b;
    int n;
    reset = 1'b0;
    rxd   = 1'b1;
    ack   = 1'b0;
    model_reset();
    tick(3);
    check_model("reset");
    reset = 1'b1;
    tick(4);

    // single byte with exact irr timing
    drive_bits(8'hA5, 1'b1);
    tick(10);
    chk("a5.irr_before", {15'd0, irr}, 16'd0);
    tick(1);
    chk("a5.irr_rise", {15'd0, irr}, 16'd1);
    chk("a5.data", {8'd0, rx_data}, 16'h00A5);
    tick(5);
    model_frame(8'hA5, 1'b1);
    do_ack("a5");
    tick(4);
    check_model("a5.idle");

    // glitch then valid byte
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(3 * C);
    check_model("glitch");
    send_frame(8'h3C, 1'b1);
    model_frame(8'h3C, 1'b1);
    check_model("3c");
    do_ack("3c");

    // pending buffer, re-raise exactly two cycles after ack drops
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    model_frame(8'h11, 1'b1);
    model_frame(8'h22, 1'b1);
    check_model("pend");
    ack = 1'b1;
    tick(1);
    chk("pend.irr_fall", {15'd0, irr}, 16'd0);
    ack = 1'b0;
    tick(1);
    chk("pend.irr_gap", {15'd0, irr}, 16'd0);
    tick(1);
    chk("pend.irr_rerise", {15'd0, irr}, 16'd1);
    chk("pend.data", {8'd0, rx_data}, 16'h0022);
    m_valid = 1'b1;
    m_data  = m_pend.pop_front();
    m_ovr   = 1'b0;
    do_ack("pend2");

    // overrun
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    send_frame(8'h03, 1'b1);
    model_frame(8'h01, 1'b1);
    model_frame(8'h02, 1'b1);
    model_frame(8'h03, 1'b1);
    check_model("ovr");
    while (m_valid) do_ack("ovr_drain");
    tick(5);
    check_model("ovr.lost");

    // frame error, break, recovery
    send_frame(8'h55, 1'b0);
    model_frame(8'h55, 1'b0);
    tick(20 * C);
    check_model("ferr.break");
    rxd = 1'b1;
    tick(2 * C);
    check_model("ferr.idle");
    send_frame(8'h7E, 1'b1);
    model_frame(8'h7E, 1'b1);
    check_model("7e");
    do_ack("7e");

    // randomized bursts of 1..3 back-to-back bytes, then drain
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        send_frame(b, 1'b1);
        model_frame(b, 1'b1);
      end
      tick($urandom_range(0, 20));
      check_model("rand");
      while (m_valid) do_ack("rand_drain");
      tick($urandom_range(1, 10));
    end

    // reset during DATA of 0xFF with a byte already offered
    send_frame(8'h5A, 1'b1);
    model_frame(8'h5A, 1'b1);
    check_model("pre_rst");
    rxd = 1'b0;
    tick(C);
    rxd = 1'b1;
    tick(4 * C);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    model_reset();
    check_model("mid_rst");
    tick(5 * C - 1);
    check_model("post_rst");
    send_frame(8'h80, 1'b1);
    model_frame(8'h80, 1'b1);
    check_model("80");
    do_ack("80");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
